// File: rtl/ram_sdp_param.sv
// Simple dual-port RAM with byte enables and a self-clearing init sequence after reset.
// Latency: read data and valid appear one cycle after an accepted read; writes land at the same edge.
// Backpressure: none; busy is high for DEPTH cycles after reset and all accesses are dropped meanwhile.
module ram_sdp_param #(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic                          wr_en,
    input  logic [$clog2(DEPTH)-1:0]      wr_addr,
    input  logic [DATA_W/8-1:0]           wr_be,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          rd_en,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid,
    output logic                          busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;
    logic                wr_acc;
    logic                rd_acc;
    logic                init_we;

    // Accesses only count in READY with chip enable; init writes are held off while reset is asserted
    // so that reset itself never disturbs memory contents.
    assign wr_acc  = (state == READY) && ce && wr_en;
    assign rd_acc  = (state == READY) && ce && rd_en;
    assign init_we = rst_n && (state == INIT);

    // Read word with write-first bypass: bytes being written to the same address this cycle are forwarded.
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_acc && (wr_addr == rd_addr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*8 +: 8] = data_in[i*8 +: 8];
                end
            end
        end
    end

    // Memory array: init sweep writes whole words, user writes touch only enabled bytes; no reset on storage.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt] <= INIT_VAL;
        end else if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= data_in[i*8 +: 8];
                end
            end
        end
    end

    // Control FSM: INIT sweeps cnt over every word, then READY serves reads with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            cnt      <= '0;
            busy     <= 1'b1;
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                INIT: begin
                    valid <= 1'b0;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    valid <= rd_acc;
                    if (rd_acc) begin
                        data_out <= rd_word;
                    end
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                    valid <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param at DATA_W=16, DEPTH=16, INIT_VAL=0.
// Inputs change and outputs are sampled just after the falling edge.
module tb_ram_sdp_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] data_in;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] data_out;
    logic        valid;
    logic        busy;

    int tests = 0;
    int fails = 0;

    ram_sdp_param #(
        .DATA_W   (16),
        .DEPTH    (16),
        .INIT_VAL (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ce = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; data_in = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Counts edges until busy drops; optionally pokes a write/read at init cycle 5.
    task automatic count_init(input string tag, input bit poke);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (poke && n == 4) begin
                ce = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_be = 2'b11; data_in = 16'hFFFF;
                rd_en = 1'b1; rd_addr = 4'd2;
            end
            cyc();
            n++;
            if (poke && n == 5) begin
                check({tag, "_valid_in_init"}, {31'd0, valid}, 32'd0);
                idle();
            end
        end
        check(tag, n, 32'd16);
    endtask

    task automatic read_all_zero(input string tag);
        int bad = 0;
        for (int a = 0; a < 16; a++) begin
            ce = 1'b1; rd_en = 1'b1; rd_addr = 4'(a);
            cyc();
            if (data_out !== 16'h0000 || valid !== 1'b1) bad++;
        end
        idle();
        check(tag, bad, 32'd0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        cyc(); cyc();
        check("rst_data_out", {16'd0, data_out}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);

        // Release and measure INIT, with an ignored write at init cycle 5
        rst_n = 1'b1;
        count_init("init_busy_len", 1'b1);
        check("busy_after_init", {31'd0, busy}, 32'd0);
        read_all_zero("init_all_zero");
        ce = 1'b1; rd_en = 1'b1; rd_addr = 4'd2;
        cyc();
        check("busy_ignore_addr2", {16'd0, data_out}, 32'h0000);
        idle();

        // Byte enables
        ce = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_be = 2'b11; data_in = 16'hABCD;
        cyc();
        wr_be = 2'b01; data_in = 16'h1234;
        cyc();
        wr_be = 2'b00; data_in = 16'hFFFF;
        cyc();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
        cyc();
        check("be_merge_data", {16'd0, data_out}, 32'hAB34);
        check("be_merge_valid", {31'd0, valid}, 32'd1);
        idle();
        cyc();
        check("no_read_valid", {31'd0, valid}, 32'd0);
        check("no_read_hold", {16'd0, data_out}, 32'hAB34);

        // Read-during-write, same address: write-first per byte
        ce = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_be = 2'b10; data_in = 16'h5555;
        rd_en = 1'b1; rd_addr = 4'd7;
        cyc();
        check("rdw_data", {16'd0, data_out}, 32'h5500);
        check("rdw_valid", {31'd0, valid}, 32'd1);

        // Independent ports: write addr 8 while reading addr 3
        wr_addr = 4'd8; wr_be = 2'b11; data_in = 16'h0F0F; rd_addr = 4'd3;
        cyc();
        check("dual_port_rd3", {16'd0, data_out}, 32'hAB34);
        wr_en = 1'b0; rd_addr = 4'd8;
        cyc();
        check("dual_port_rd8", {16'd0, data_out}, 32'h0F0F);
        rd_addr = 4'd7;
        cyc();
        check("rdw_stored", {16'd0, data_out}, 32'h5500);

        // ce gating
        ce = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_be = 2'b11; data_in = 16'h1111;
        rd_en = 1'b1; rd_addr = 4'd4;
        cyc();
        check("ce0_valid", {31'd0, valid}, 32'd0);
        check("ce0_hold", {16'd0, data_out}, 32'h5500);
        ce = 1'b1; wr_en = 1'b0;
        cyc();
        check("ce0_no_write", {16'd0, data_out}, 32'h0000);
        check("ce1_valid", {31'd0, valid}, 32'd1);

        // Reset during a read
        rd_addr = 4'd3;
        cyc();
        check("pre_rst_read", {16'd0, data_out}, 32'hAB34);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_data_out", {16'd0, data_out}, 32'h0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        idle();
        cyc(); cyc();
        rst_n = 1'b1;
        count_init("reinit_busy_len", 1'b0);
        read_all_zero("reinit_all_zero");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_sdp_param.md
RAM_SDP_PARAM -- requirements
Module: ram_sdp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits; a multiple of 8 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 16: number of words; a power of 2 and at least 2.
REQ-003 SHALL have parameter INIT_VAL, default 0: value written to every word by the init sequence.
REQ-004 SHALL derive ADDR_W = log2(DEPTH) and BE_W = DATA_W/8 internally; neither is user-set.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port ce, input, 1 bit: chip enable; gates all reads and writes.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-010 SHALL have port wr_be, input, BE_W bits: byte enables; bit i selects data_in[8i+7:8i].
REQ-011 SHALL have port data_in, input, DATA_W bits: write data.
REQ-012 SHALL have port rd_en, input, 1 bit: read request.
REQ-013 SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-014 SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-015 SHALL have port valid, output, 1 bit: data_out carries fresh read data this cycle.
REQ-016 SHALL have port busy, output, 1 bit: init sequence in progress; all accesses are ignored while high.

Function
REQ-017 SHALL implement a two-state FSM, INIT and READY.
REQ-018 INIT SHALL write INIT_VAL to word cnt each cycle, with cnt counting 0..DEPTH-1.
REQ-019 After word DEPTH-1 is written, the FSM SHALL move to READY, so INIT lasts exactly DEPTH cycles.
REQ-020 busy SHALL be 1 in INIT and 0 in READY; READY SHALL persist until reset.
REQ-021 In INIT, wr_en and rd_en SHALL be ignored: no user write, valid=0, data_out held.
REQ-022 In READY with ce=1 and wr_en=1, each byte i with wr_be[i]=1 SHALL update mem[wr_addr] byte i at the clock edge; bytes with wr_be[i]=0 SHALL keep their value.
REQ-023 A write with wr_be all-zero SHALL leave memory unchanged.
REQ-024 In READY with ce=1 and rd_en=1 at edge N, data_out SHALL show mem[rd_addr] after edge N, and valid SHALL be 1 for that one cycle (latency 1).
REQ-025 Read and write SHALL be independent ports, and both may occur in the same cycle.
REQ-026 When rd_addr==wr_addr with both enabled, the read SHALL be write-first: enabled bytes come from data_in, the other bytes come from the old word.
REQ-027 In any cycle without an accepted read (ce=0, rd_en=0 or INIT), valid SHALL be 0 and data_out SHALL hold its last value.
REQ-028 With ce=0, memory SHALL be unchanged regardless of wr_en, wr_be and data_in.
REQ-029 Every address 0..DEPTH-1 SHALL be legal; there SHALL be no out-of-range case.

Reset
REQ-030 While rst_n=0: data_out=0, valid=0, busy=1, state=INIT, cnt=0.
REQ-031 Memory contents SHALL NOT be cleared by the reset itself; they are cleared only by the INIT sequence after release.
REQ-032 Reset asserted mid-INIT or mid-READY SHALL abort any access, and on release INIT SHALL restart from cnt=0 for a full DEPTH cycles.

Verification (DATA_W=16, DEPTH=16, INIT_VAL=0)
REQ-033 Init: release rst_n -> busy=1 for exactly 16 cycles, then 0; read each address 0..15 -> data_out=0x0000 with valid=1.
REQ-034 Byte enables: write addr 3 data 0xABCD be=11, then write addr 3 data 0x1234 be=01, then read addr 3 -> data_out=0xAB34.
REQ-035 Read-during-write: addr 7 holds 0x0000; same cycle write addr 7 data 0x5555 be=10 and read addr 7 -> next cycle data_out=0x5500, valid=1.
REQ-036 Busy ignore: during INIT cycle 5, write addr 2 data 0xFFFF be=11 -> after INIT, read addr 2 -> 0x0000.
REQ-037 ce gating: ce=0 with wr_en=1 addr 4 data 0x1111 and rd_en=1 -> valid=0 and data_out unchanged; a later read of addr 4 -> 0x0000.
REQ-038 Reset mid-op: assert rst_n during a read -> data_out=0, valid=0, busy=1 immediately; after release, busy=1 for 16 cycles and all words read 0x0000.
